// File: rtl/dc_alu_pkg.sv
// Shared types and constants for the shared-ALU scheduler.
package dc_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // ALU op encodings (s3 s2 s1 s0)
  localparam logic [3:0] OP_ADD    = 4'b1111;
  localparam logic [3:0] OP_SUB    = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b1101;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b1001;
  localparam logic [3:0] OP_NOT    = 4'b0001;
  localparam logic [3:0] OP_CAT_AB = 4'b1110;
  localparam logic [3:0] OP_CAT_BA = 4'b0110;
  localparam logic [3:0] OP_SHL2   = 4'b1010;
  localparam logic [3:0] OP_SHR2   = 4'b0010;
  localparam logic [3:0] OP_PASS_B = 4'b1100;
  localparam logic [3:0] OP_PASS_C = 4'b0100;

  // Result for the unused encodings 0000 and 1000
  localparam logic [7:0] ALU_DEFAULT = 8'h55;

endpackage

// File: rtl/dc_alu_core.sv
// Purely combinational 8-bit ALU; divide treats a zero divisor as 1.
module dc_alu_core
  import dc_alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result
);

  logic [15:0] prod;
  logic [7:0]  div_b;

  assign prod  = {8'd0, a} * {8'd0, b};
  assign div_b = (b == 8'd0) ? 8'd1 : b;

  // Select the result for the requested op; unused codes fall to the default pattern
  always_comb begin
    result = ALU_DEFAULT;
    case (op)
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_MUL:    result = prod[7:0];
      OP_DIV:    result = a / div_b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOT:    result = ~a;
      OP_CAT_AB: result = {a[6:0], b[7]};
      OP_CAT_BA: result = {b[6:0], a[7]};
      OP_SHL2:   result = {a[5:0], 2'b00};
      OP_SHR2:   result = {2'b00, a[7:2]};
      OP_PASS_B: result = b;
      OP_PASS_C: result = b;
      default:   result = ALU_DEFAULT;
    endcase
  end

endmodule

// File: rtl/dc_alu_sched.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters,
// with a single in-flight slot and a valid/ready response channel.
module dc_alu_sched
  import dc_alu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*4-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int DC_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    id_reg;
  logic [7:0]         a_reg, b_reg;
  logic [3:0]         op_reg;
  logic [DC_W-1:0]    cnt_reg;
  logic [7:0]         rsp_data_reg;
  logic [CNT_W-1:0]   op_count_reg;

  logic [7:0]         a_arr  [NUM_REQ];
  logic [7:0]         b_arr  [NUM_REQ];
  logic [3:0]         op_arr [NUM_REQ];

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    cand;
  logic               grant;
  logic [7:0]         alu_result;

  // Unpack the flat request buses into per-requester lanes
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[8*gi +: 8];
      assign b_arr[gi]  = req_b[8*gi +: 8];
      assign op_arr[gi] = req_op[4*gi +: 4];
    end
  endgenerate

  // Round-robin search: first valid index strictly after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant only from IDLE and never while reset is held, so outputs read 0 in reset
  assign grant     = (state_reg == IDLE) && win_found && rst_n;
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;

  dc_alu_core u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: accept -> execute until counter expires -> hold until consumed
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = EXEC;
      EXEC:    if (cnt_reg == '0) state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, arbitration pointer, execute counter, result and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= ID_W'(NUM_REQ - 1);
      id_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      cnt_reg      <= '0;
      rsp_data_reg <= '0;
      op_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            a_reg   <= a_arr[win_idx];
            b_reg   <= b_arr[win_idx];
            op_reg  <= op_arr[win_idx];
            id_reg  <= win_idx;
            ptr_reg <= win_idx;
            cnt_reg <= (op_arr[win_idx] == OP_DIV) ? DC_W'(DIV_CYCLES - 1) : '0;
          end
        end
        EXEC: begin
          if (cnt_reg != '0) cnt_reg      <= cnt_reg - 1'b1;
          else               rsp_data_reg <= alu_result;
        end
        HOLD: begin
          if (rsp_ready) op_count_reg <= op_count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = id_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_dc_alu_sched.sv
// Randomized self-checking bench for dc_alu_sched against a transaction-level model.
module tb_dc_alu_sched;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int CW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic [N*4-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [7:0]      rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            busy;
  logic [CW-1:0]   op_count;

  logic [7:0] pa [N];
  logic [7:0] pb [N];
  logic [3:0] pop[N];

  int errors = 0;
  int checks = 0;
  int model_ptr;
  int model_cnt;
  int last_data;

  always #5 clk = ~clk;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8]  = pa[i];
      req_b[8*i +: 8]  = pb[i];
      req_op[4*i +: 4] = pop[i];
    end
  end

  dc_alu_sched #(.NUM_REQ(N), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU written as plain integer arithmetic
  function automatic int alu_ref(int a, int b, int op);
    case (op)
      15: return (a + b) % 256;
      7:  return (a - b + 256) % 256;
      11: return (a * b) % 256;
      3:  return a / ((b == 0) ? 1 : b);
      13: return a & b;
      5:  return a | b;
      9:  return a ^ b;
      1:  return 255 - a;
      14: return ((a * 2) % 256) + (b / 128);
      6:  return ((b * 2) % 256) + (a / 128);
      10: return (a * 4) % 256;
      2:  return a / 4;
      12, 4: return b;
      default: return 85;
    endcase
  endfunction

  function automatic int rr_pick(int ptr, logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_payload(input int i);
    pa[i]  = 8'($urandom_range(0, 255));
    pb[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    pop[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic set_payload(input int i, input int a, input int b, input int op);
    pa[i]  = 8'(a);
    pb[i]  = 8'(b);
    pop[i] = 4'(op);
  endtask

  // One transaction: called at posedge+1 with the DUT in IDLE
  task automatic run_txn(input logic [N-1:0] mask, input int stall);
    int w, exp_data, exp_lat, lat;
    w        = rr_pick(model_ptr, mask);
    exp_data = alu_ref(pa[w], pb[w], pop[w]);
    exp_lat  = (pop[w] == 4'b0011) ? 1 + DC : 2;
    req_valid = mask;
    rsp_ready = (stall == 0);
    @(negedge clk);
    chk("grant", req_ready, 32'(1) << w);
    chk("busy_idle", busy, 0);
    model_ptr = w;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) rand_payload(w);
      lat++;
      @(negedge clk);
      if (!rsp_valid) chk("rdy_exec", req_ready, 0);
    end while (!rsp_valid && lat < 40);
    chk("latency", lat, exp_lat);
    chk("data", rsp_data, exp_data);
    chk("id", rsp_id, w);
    chk("busy_hold", busy, 1);
    last_data = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, exp_data);
      chk("stall_id", rsp_id, w);
      chk("stall_rdy", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("last_hold", rsp_valid, 1);
    end
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % (1 << CW);
    chk("op_count", op_count, model_cnt);
    chk("rsp_done", rsp_valid, 0);
    $display("txn id=%0d data=%0h lat=%0d stall=%0d count=%0d", w, last_data, lat, stall, op_count);
  endtask

  initial begin
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) rand_payload(i);
    model_ptr = N - 1;
    model_cnt = 0;
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors with fixed expected results
    set_payload(0, 8'h12, 8'h34, 4'b1111); run_txn(4'b0001, 0); chk("add", last_data, 8'h46);
    set_payload(1, 100, 7, 4'b0011);       run_txn(4'b0010, 0); chk("div", last_data, 14);
    set_payload(2, 100, 0, 4'b0011);       run_txn(4'b0100, 0); chk("div0", last_data, 100);
    set_payload(3, 8'hFF, 8'h02, 4'b1011); run_txn(4'b1000, 0); chk("mul", last_data, 8'hFE);
    set_payload(0, 8'h00, 8'h01, 4'b0111); run_txn(4'b0001, 0); chk("sub", last_data, 8'hFF);
    set_payload(1, 8'h81, 8'h80, 4'b1110); run_txn(4'b0010, 0); chk("cat", last_data, 8'h03);
    set_payload(2, 8'h3C, 8'hA5, 4'b1000); run_txn(4'b0100, 0); chk("dflt", last_data, 8'h55);
    set_payload(3, 8'h10, 8'h20, 4'b1111); run_txn(4'b1000, 5); chk("stall", last_data, 8'h30);

    // All requesters valid continuously: rotation 0,1,2,3,0,1
    for (int t = 0; t < 6; t++) run_txn(4'b1111, 0);

    // Random masks, ops and back-pressure; enough completions to wrap op_count
    for (int t = 0; t < 260; t++) begin
      m = 4'($urandom_range(1, 15));
      run_txn(m, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset in the middle of a divide
    set_payload(2, 200, 3, 4'b0011);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", op_count, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_id", rsp_id, 0);
    model_ptr = N - 1;
    model_cnt = 0;
    for (int i = 0; i < N; i++) rand_payload(i);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(4'b1111, 0);
    chk("post_rst_id", rsp_id, 0);
    run_txn(4'b1111, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
